sprite_pixel_engine: RTL and testbench

- Parametrised successor to the fixed 4bpp draw-pixels path in the graphics block.
- Decodes the draw-pixels command (opcode 0x12) from the SPI-side opcode/operand stream.
- Unpacks 1/2/4/8 bits-per-pixel data via a byte FIFO and emits clipped, palette-offset pixel writes over a valid/ready handshake toward the frame-buffer writer.
- Sits in the SPI clock domain, between the command decoder and the display buffer write arbiter.

---
 rtl/sprite_pixel_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_sprite_pixel_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_engine.sv
// Draw-pixels command engine: decodes the opcode 0x12 header, buffers data bytes,
// unpacks 1/2/4/8 bpp pixels and issues clipped, palette-offset pixel writes.
module sprite_pixel_engine #(
  parameter logic [7:0]  OPCODE         = 8'h12,
  parameter int unsigned COORD_WIDTH    = 10,
  parameter int unsigned COLOR_WIDTH    = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned DISPLAY_WIDTH  = 640,
  parameter int unsigned DISPLAY_HEIGHT = 400
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [7:0]             op_code_in,
  input  logic                   op_code_valid_in,
  input  logic [7:0]             operand_in,
  input  logic                   operand_valid_in,
  input  logic [31:0]            operand_count_in,
  output logic [COORD_WIDTH-1:0] pixel_x_out,
  output logic [COORD_WIDTH-1:0] pixel_y_out,
  output logic [COLOR_WIDTH-1:0] pixel_color_out,
  output logic                   pixel_valid_out,
  input  logic                   pixel_ready_in,
  output logic                   busy_out,
  output logic                   overflow_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = COORD_WIDTH + 1;
  localparam bit          WIDE_COLOR = (COLOR_WIDTH >= 8);
  localparam logic [SW-1:0] DISP_W = SW'(DISPLAY_WIDTH);
  localparam logic [SW-1:0] DISP_H = SW'(DISPLAY_HEIGHT);
  localparam logic [PW-1:0] FULL_FILL = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                   op_valid_prev_q;
  logic                   cap_c;
  logic                   cnt_first_c;
  logic                   cnt_last_hdr_c;
  logic                   cnt_data_c;
  logic                   start_c;
  logic                   hdr_we_c;

  logic [7:0]             hdr_hi_q;
  logic [COORD_WIDTH-1:0] x_start_q;
  logic [COORD_WIDTH-1:0] y_start_q;
  logic [COORD_WIDTH-1:0] width_q;
  logic [1:0]             bpp_log_q;
  logic [7:0]             offset_q;

  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]          wr_ptr_d, rd_ptr_d;
  logic [PW-1:0]          fill_c;
  logic                   fifo_empty_c;
  logic                   fifo_full_c;
  logic [7:0]             head_c;

  logic                   push_req_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   drop_c;
  logic                   advance_c;

  logic [2:0]             idx_q;
  logic [COORD_WIDTH-1:0] col_q;
  logic [COORD_WIDTH-1:0] row_q;
  logic [3:0]             shamt_c;
  logic [7:0]             aligned_c;
  logic [7:0]             value_c;
  logic [COLOR_WIDTH-1:0] color_c;
  logic                   last_c;
  logic                   width_zero_c;
  logic [SW-1:0]          x_sum_c;
  logic [SW-1:0]          y_sum_c;
  logic                   in_range_c;
  logic                   col_wrap_c;

  // Map the header colour count onto log2(bits per pixel).
  function automatic logic [1:0] bpp_log_of(input logic [7:0] colors);
    logic [1:0] r;
    if (colors == 8'd1 || colors == 8'd2) begin
      r = 2'd0;
    end else if (colors == 8'd3 || colors == 8'd4) begin
      r = 2'd1;
    end else if (colors >= 8'd5 && colors <= 8'd16) begin
      r = 2'd2;
    end else begin
      r = WIDE_COLOR ? 2'd3 : 2'd2;
    end
    return r;
  endfunction

  // Operand byte capture on the rising edge of operand_valid_in.
  always_comb begin
    cap_c          = operand_valid_in && !op_valid_prev_q && op_code_valid_in
                     && (op_code_in == OPCODE);
    cnt_first_c    = (operand_count_in == 32'd1);
    cnt_last_hdr_c = (operand_count_in == 32'd8);
    cnt_data_c     = (operand_count_in >= 32'd9);
    start_c        = cap_c && cnt_first_c && (state_q == IDLE);
    hdr_we_c       = start_c || (cap_c && (state_q == HEADER));
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_c) state_d = HEADER;
      end
      HEADER: begin
        if (!op_code_valid_in)                state_d = IDLE;
        else if (cap_c && cnt_last_hdr_c)     state_d = STREAM;
      end
      STREAM: begin
        if (!op_code_valid_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty_c && !pixel_valid_out) state_d = IDLE;
      end
    endcase
  end

  // Header fields; 16-bit values keep only their low COORD_WIDTH bits.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      hdr_hi_q  <= 8'd0;
      x_start_q <= '0;
      y_start_q <= '0;
      width_q   <= '0;
      bpp_log_q <= 2'd0;
      offset_q  <= 8'd0;
    end else if (hdr_we_c) begin
      case (operand_count_in)
        32'd1, 32'd3, 32'd5: hdr_hi_q  <= operand_in;
        32'd2:               x_start_q <= COORD_WIDTH'({hdr_hi_q, operand_in});
        32'd4:               y_start_q <= COORD_WIDTH'({hdr_hi_q, operand_in});
        32'd6:               width_q   <= COORD_WIDTH'({hdr_hi_q, operand_in});
        32'd7:               bpp_log_q <= bpp_log_of(operand_in);
        32'd8:               offset_q  <= operand_in;
        default: ;
      endcase
    end
  end

  // FIFO bookkeeping; a pop while full frees the slot for a same-cycle push.
  always_comb begin
    fill_c       = wr_ptr_q - rd_ptr_q;
    fifo_empty_c = (fill_c == '0);
    fifo_full_c  = (fill_c == FULL_FILL);
    head_c       = mem_q[rd_ptr_q[AW-1:0]];
    advance_c    = !fifo_empty_c && (!pixel_valid_out || pixel_ready_in);
    pop_c        = advance_c && (last_c || width_zero_c);
    push_req_c   = cap_c && cnt_data_c && (state_q == STREAM);
    push_c       = push_req_c && (!fifo_full_c || pop_c);
    drop_c       = (push_req_c && !push_c) || (cap_c && (state_q == DRAIN));
    wr_ptr_d     = wr_ptr_q + PW'(push_c);
    rd_ptr_d     = rd_ptr_q + PW'(pop_c);
  end

  always_ff @(posedge clock_in) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= operand_in;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      op_valid_prev_q <= 1'b0;
      overflow_out    <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      op_valid_prev_q <= operand_valid_in;
      busy_out        <= (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
      if (start_c)     overflow_out <= 1'b0;
      else if (drop_c) overflow_out <= 1'b1;
    end
  end

  // Pixel extraction from the FIFO head byte, MSB first, plus position/clip.
  always_comb begin
    shamt_c   = 4'({1'b0, idx_q} << bpp_log_q);
    aligned_c = head_c << shamt_c;
    case (bpp_log_q)
      2'd0:    value_c = {7'd0, aligned_c[7]};
      2'd1:    value_c = {6'd0, aligned_c[7:6]};
      2'd2:    value_c = {4'd0, aligned_c[7:4]};
      default: value_c = aligned_c;
    endcase
    color_c      = COLOR_WIDTH'(9'(value_c) + 9'(offset_q));
    last_c       = (idx_q == (3'd7 >> bpp_log_q));
    width_zero_c = (width_q == '0);
    x_sum_c      = SW'(x_start_q) + SW'(col_q);
    y_sum_c      = SW'(y_start_q) + SW'(row_q);
    in_range_c   = (x_sum_c < DISP_W) && (y_sum_c < DISP_H);
    col_wrap_c   = (col_q == width_q - COORD_WIDTH'(1));
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      idx_q           <= 3'd0;
      col_q           <= '0;
      row_q           <= '0;
      pixel_valid_out <= 1'b0;
      pixel_x_out     <= '0;
      pixel_y_out     <= '0;
      pixel_color_out <= '0;
    end else begin
      if (advance_c) begin
        if (width_zero_c) begin
          idx_q           <= 3'd0;
          pixel_valid_out <= 1'b0;
        end else begin
          idx_q           <= last_c ? 3'd0 : 3'(idx_q + 3'd1);
          pixel_valid_out <= in_range_c;
          if (in_range_c) begin
            pixel_x_out     <= x_sum_c[COORD_WIDTH-1:0];
            pixel_y_out     <= y_sum_c[COORD_WIDTH-1:0];
            pixel_color_out <= color_c;
          end
          if (col_wrap_c) begin
            col_q <= '0;
            row_q <= row_q + COORD_WIDTH'(1);
          end else begin
            col_q <= col_q + COORD_WIDTH'(1);
          end
        end
      end else if (pixel_ready_in) begin
        pixel_valid_out <= 1'b0;
      end
      // A new command restarts the raster walk.
      if (start_c) begin
        idx_q <= 3'd0;
        col_q <= '0;
        row_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_engine.sv
// Bench for sprite_pixel_engine: directed vector table, multi-cycle corner
// sequences and random commands scored against a pixel-list reference model.
module tb_sprite_pixel_engine;

  localparam int unsigned CW    = 10;
  localparam int unsigned KW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    op_code_in;
  logic          op_code_valid_in;
  logic [7:0]    operand_in;
  logic          operand_valid_in;
  logic [31:0]   operand_count_in;
  logic [CW-1:0] pixel_x_out;
  logic [CW-1:0] pixel_y_out;
  logic [KW-1:0] pixel_color_out;
  logic          pixel_valid_out;
  logic          pixel_ready_in;
  logic          busy_out;
  logic          overflow_out;

  sprite_pixel_engine #(
    .OPCODE(8'h12), .COORD_WIDTH(CW), .COLOR_WIDTH(KW), .FIFO_DEPTH(DEPTH),
    .DISPLAY_WIDTH(640), .DISPLAY_HEIGHT(400)
  ) dut (
    .clock_in(clk), .reset_in(rst), .op_code_in(op_code_in),
    .op_code_valid_in(op_code_valid_in), .operand_in(operand_in),
    .operand_valid_in(operand_valid_in), .operand_count_in(operand_count_in),
    .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
    .pixel_color_out(pixel_color_out), .pixel_valid_out(pixel_valid_out),
    .pixel_ready_in(pixel_ready_in), .busy_out(busy_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct {
    int xs; int ys; int ws; int cols; int off;
    logic [63:0] d; int n;
    int exp_n; int fx; int fy; int fc; int lx; int ly; int lc;
  } vec_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;
  bit   ready_rand  = 1'b0;
  bit   ready_force = 1'b1;
  logic ovf_after_first;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int key(input pix_t p);
    return (p.x << 16) | (p.y << 4) | p.c;
  endfunction

  // Ready driver: forced level or 75% random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pixel_ready_in = ready_rand ? ($urandom_range(3) != 0) : ready_force;
    end
  end

  // Monitor: records accepted pixels and checks outputs hold during back-pressure.
  initial begin
    bit hold_prev = 1'b0;
    int hold_val  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev)
          chk("hold", int'({pixel_valid_out, pixel_x_out, pixel_y_out, pixel_color_out}), hold_val);
        if (pixel_valid_out && pixel_ready_in) begin
          pix_t p;
          p.x = int'(pixel_x_out);
          p.y = int'(pixel_y_out);
          p.c = int'(pixel_color_out);
          got_q.push_back(p);
        end
        hold_prev = pixel_valid_out && !pixel_ready_in;
        hold_val  = int'({pixel_valid_out, pixel_x_out, pixel_y_out, pixel_color_out});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int cnt, input int gap);
    operand_in       = b;
    operand_count_in = 32'(cnt);
    operand_valid_in = 1'b1;
    tick;
    operand_valid_in = 1'b0;
    repeat (gap) tick;
  endtask

  task automatic send_header(input int xs, input int ys, input int ws, input int cols,
                             input int off, input int gap);
    send_byte(8'(xs >> 8), 1, gap);
    ovf_after_first = overflow_out;
    send_byte(8'(xs), 2, gap);
    send_byte(8'(ys >> 8), 3, gap);
    send_byte(8'(ys), 4, gap);
    send_byte(8'(ws >> 8), 5, gap);
    send_byte(8'(ws), 6, gap);
    send_byte(8'(cols), 7, gap);
    send_byte(8'(off), 8, gap);
  endtask

  task automatic send_cmd(input int xs, input int ys, input int ws, input int cols,
                          input int off, input logic [63:0] d, input int n,
                          input int gap, input bit finish);
    op_code_in       = 8'h12;
    op_code_valid_in = 1'b1;
    tick;
    send_header(xs, ys, ws, cols, off, gap);
    for (int i = 0; i < n; i++) send_byte(d[63-8*i -: 8], 9 + i, gap);
    if (finish) begin
      op_code_valid_in = 1'b0;
      tick;
    end
  endtask

  // Reference: pixel k of the command sits at (x0 + k mod w, y0 + k div w).
  task automatic model(input int xs, input int ys, input int ws, input int cols,
                       input int off, input logic [63:0] d, input int n);
    int x0, y0, w, bpp, k, v, x, y;
    logic [7:0] b;
    pix_t p;
    x0 = xs % 1024;
    y0 = ys % 1024;
    w  = ws % 1024;
    if (cols >= 1 && cols <= 2)      bpp = 1;
    else if (cols >= 3 && cols <= 4) bpp = 2;
    else                             bpp = 4;
    k = 0;
    for (int i = 0; i < n; i++) begin
      b = d[63-8*i -: 8];
      for (int j = 0; j < 8 / bpp; j++) begin
        v = (int'(b) >> (8 - bpp * (j + 1))) % (1 << bpp);
        if (w != 0) begin
          x = x0 + k % w;
          y = y0 + k / w;
          if (x < 640 && y < 400) begin
            p.x = x;
            p.y = y;
            p.c = (v + off) % 16;
            exp_q.push_back(p);
          end
          k++;
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy_out) break;
      tick;
    end
    chk(name, int'(busy_out), 0);
    tick;
  endtask

  task automatic check_cmd(input string name);
    int n;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_pix"}, key(got_q[i]), key(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{'h32, 'h64, 'h14, 'h10, 0, 64'h123456789ABCDEF0, 8, 16, 50, 100, 1, 65, 100, 0};
    vecs[1] = '{10, 20, 4, 2, 3, 64'hA500000000000000, 1, 8, 10, 20, 4, 13, 21, 4};
    vecs[2] = '{'h27E, 5, 4, 16, 0, 64'h1234567800000000, 4, 4, 638, 5, 1, 639, 6, 6};
    vecs[3] = '{0, 399, 2, 4, 1, 64'h1B00000000000000, 1, 2, 0, 399, 1, 1, 399, 2};
    vecs[4] = '{0, 0, 0, 16, 0, 64'hFFFF000000000000, 2, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{'hFC05, 'h0403, 'h0402, 0, 'h0F, 64'h0100000000000000, 1, 2, 5, 3, 15, 6, 3, 0};
    vecs[6] = '{1, 1, 3, 3, 0, 64'hE400000000000000, 1, 4, 1, 1, 3, 1, 2, 0};
    vecs[7] = '{0, 0, 8, 17, 0, 64'hAB00000000000000, 1, 2, 0, 0, 10, 1, 0, 11};

    rst = 1'b1;
    op_code_in = 8'h00;
    op_code_valid_in = 1'b0;
    operand_in = 8'h00;
    operand_valid_in = 1'b0;
    operand_count_in = 32'd0;
    pixel_ready_in = 1'b1;
    repeat (3) tick;
    chk("rst_valid", int'(pixel_valid_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_ovf", int'(overflow_out), 0);
    chk("rst_xyc", int'({pixel_x_out, pixel_y_out, pixel_color_out}), 0);
    rst = 1'b0;
    repeat (2) tick;

    // Directed vector table with constant ready.
    foreach (vecs[v]) begin
      send_cmd(vecs[v].xs, vecs[v].ys, vecs[v].ws, vecs[v].cols, vecs[v].off,
               vecs[v].d, vecs[v].n, 9, 1'b1);
      wait_idle("vec_idle");
      chk("vec_n", got_q.size(), vecs[v].exp_n);
      if (vecs[v].exp_n > 0 && got_q.size() > 0) begin
        chk("vec_first", key(got_q[0]),
            key('{vecs[v].fx, vecs[v].fy, vecs[v].fc}));
        chk("vec_last", key(got_q[got_q.size()-1]),
            key('{vecs[v].lx, vecs[v].ly, vecs[v].lc}));
      end
      model(vecs[v].xs, vecs[v].ys, vecs[v].ws, vecs[v].cols, vecs[v].off,
            vecs[v].d, vecs[v].n);
      check_cmd("vec");
    end

    // First-pixel latency: valid two cycles after the data byte capture.
    op_code_in = 8'h12;
    op_code_valid_in = 1'b1;
    tick;
    send_header(100, 50, 10, 16, 0, 2);
    operand_in = 8'hC3;
    operand_count_in = 32'd9;
    operand_valid_in = 1'b1;
    tick;
    chk("lat_cycle1", int'(pixel_valid_out), 0);
    tick;
    chk("lat_cycle2", int'(pixel_valid_out), 1);
    operand_valid_in = 1'b0;
    tick;
    op_code_valid_in = 1'b0;
    tick;
    wait_idle("lat_idle");
    model(100, 50, 10, 16, 0, 64'hC300000000000000, 1);
    check_cmd("lat");

    // Back-pressure with a 4-deep FIFO: bytes 5 and 6 are dropped.
    ready_force = 1'b0;
    send_cmd(0, 0, 16, 16, 0, 64'h0123456789AB0000, 6, 3, 1'b1);
    repeat (10) tick;
    chk("ovf_set", int'(overflow_out), 1);
    chk("stall_valid", int'(pixel_valid_out), 1);
    ready_force = 1'b1;
    wait_idle("ovf_idle");
    chk("ovf_sticky", int'(overflow_out), 1);
    model(0, 0, 16, 16, 0, 64'h0123456700000000, 4);
    check_cmd("ovf");

    // Capture during DRAIN is ignored but flags overflow.
    ready_force = 1'b0;
    send_cmd(0, 10, 8, 16, 0, 64'h9F00000000000000, 1, 3, 1'b1);
    chk("ovf_clear", int'(ovf_after_first), 0);
    repeat (2) tick;
    op_code_valid_in = 1'b1;
    tick;
    send_byte(8'h55, 1, 2);
    op_code_valid_in = 1'b0;
    tick;
    chk("drain_ovf", int'(overflow_out), 1);
    ready_force = 1'b1;
    wait_idle("drain_idle");
    model(0, 10, 8, 16, 0, 64'h9F00000000000000, 1);
    check_cmd("drain");

    // Asynchronous reset mid-command with bytes queued.
    ready_force = 1'b0;
    send_cmd(200, 30, 8, 16, 0, 64'h1122330000000000, 3, 3, 1'b0);
    tick;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(pixel_valid_out), 0);
    chk("arst_busy", int'(busy_out), 0);
    chk("arst_ovf", int'(overflow_out), 0);
    op_code_valid_in = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    got_q.delete();
    ready_force = 1'b1;
    repeat (2) tick;
    send_cmd(200, 30, 8, 16, 0, 64'h1200000000000000, 1, 3, 1'b1);
    wait_idle("arst_idle");
    model(200, 30, 8, 16, 0, 64'h1200000000000000, 1);
    check_cmd("arst");

    // Random commands under random ready.
    ready_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int xs, ys, ws, cols, off, n;
      logic [63:0] d;
      xs   = int'($urandom_range(700));
      ys   = int'($urandom_range(420));
      ws   = int'($urandom_range(12));
      cols = int'($urandom_range(20));
      off  = int'($urandom_range(255));
      n    = int'($urandom_range(8, 1));
      d    = {$urandom, $urandom};
      send_cmd(xs, ys, ws, cols, off, d, n, 40, 1'b1);
      wait_idle("rand_idle");
      chk("rand_ovf", int'(overflow_out), 0);
      model(xs, ys, ws, cols, off, d, n);
      check_cmd("rand");
    end
    ready_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
